// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: game sequencer for the DE1 slot machine.
// Owns the credit balance and turns spin/coin presses into a play cycle.
// Drives the symbol-generator state bus, applies payouts from its done/win flags,
// and holds the result for display before returning to idle.
//
// Ports
//   clk_i       single clock
//   rst_i       synchronous, active-high reset
//   spin_i      debounced spin button (level, active-high)
//   coin_i      debounced coin button (level, active-high)
//   done_i      datapath run-complete flag
//   win_i       datapath win flag, valid one cycle after done_i rises
//   state_o     datapath state bus: 00 idle, 01 arm, 10 run, 11 result
//   credits_o   current credit balance
//   win_led_o   high throughout RESULT after a win
//   lose_led_o  high throughout RESULT after a loss
//   busy_o      high in every state except IDLE
//   err_o       one-cycle pulse when the RUN watchdog expires
//
// State      | meaning
// S_IDLE     | waiting for a spin press with enough credit
// S_ARM      | bet debited, run counter cleared (1 cycle)
// S_RUN      | datapath spinning, watchdog counting
// S_SETTLE   | done seen, win_i sampled and payout applied (1 cycle, bus stays 10)
// S_RESULT   | result shown on LEDs for RESULT_HOLD cycles
module slot_game_ctrl #(
   parameter int CREDIT_W      = 8,
   parameter int START_CREDITS = 10,
   parameter int BET_COST      = 1,
   parameter int WIN_PAYOUT    = 20,
   parameter int RESULT_HOLD   = 50_000_000,
   parameter int RUN_TIMEOUT   = 200_000_000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                spin_i,
   input  logic                coin_i,
   input  logic                done_i,
   input  logic                win_i,
   output logic [1:0]          state_o,
   output logic [CREDIT_W-1:0] credits_o,
   output logic                win_led_o,
   output logic                lose_led_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam int RUN_CNT_W  = $clog2(RUN_TIMEOUT + 1);
   localparam int HOLD_CNT_W = $clog2(RESULT_HOLD + 1);
   localparam int SUM_W      = CREDIT_W + 2;

   localparam logic [RUN_CNT_W-1:0]  RUN_LAST  = RUN_CNT_W'(RUN_TIMEOUT - 1);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESULT_HOLD - 1);

   localparam logic signed [SUM_W-1:0] BET_S    = SUM_W'(BET_COST);
   localparam logic signed [SUM_W-1:0] PAYOUT_S = SUM_W'(WIN_PAYOUT);
   localparam logic signed [SUM_W-1:0] ONE_S    = SUM_W'(1);
   localparam logic signed [SUM_W-1:0] ZERO_S   = SUM_W'(0);
   localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'((1 << CREDIT_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_SETTLE,
      S_RESULT
   } state_t;

   state_t                  state_q, state_d;
   logic [RUN_CNT_W-1:0]    run_cnt_q, run_cnt_d;
   logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [CREDIT_W-1:0]     credits_q, credits_d;
   logic                    win_r_q, win_r_d;
   logic                    spin_q, coin_q;
   logic [1:0]              st_enc_q, st_enc_d;
   logic                    win_led_q, win_led_d;
   logic                    lose_led_q, lose_led_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;

   logic                    spin_rise, coin_rise;
   logic                    debit, refund, payout;
   logic signed [SUM_W-1:0] credits_s, sum_s;
   logic                    credits_ok;

   assign spin_rise  = spin_i & ~spin_q;
   assign coin_rise  = coin_i & ~coin_q;
   assign credits_s  = {2'b00, credits_q};
   assign credits_ok = (credits_s >= BET_S);

   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      hold_cnt_d = hold_cnt_q;
      win_r_d    = win_r_q;
      debit      = 1'b0;
      refund     = 1'b0;
      payout     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (spin_rise && credits_ok) begin
               debit   = 1'b1;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            run_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            // done wins over a watchdog expiry landing on the same cycle
            if (done_i) begin
               state_d = S_SETTLE;
            end else if (run_cnt_q == RUN_LAST) begin
               refund  = 1'b1;
               state_d = S_IDLE;
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            win_r_d    = win_i;
            payout     = win_i;
            hold_cnt_d = '0;
            state_d    = S_RESULT;
         end
         S_RESULT: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // All credit sources net out in one signed sum, then clamp to the counter range.
   always_comb begin
      sum_s = credits_s;
      if (coin_rise)      sum_s = sum_s + ONE_S;
      if (refund)         sum_s = sum_s + BET_S;
      if (payout)         sum_s = sum_s + PAYOUT_S;
      if (debit)          sum_s = sum_s - BET_S;
      credits_d = sum_s[CREDIT_W-1:0];
      if (sum_s < ZERO_S)     credits_d = '0;
      else if (sum_s > MAX_S) credits_d = '1;
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      st_enc_d   = 2'b00;
      win_led_d  = 1'b0;
      lose_led_d = 1'b0;
      busy_d     = (state_d != S_IDLE);
      err_d      = refund;
      case (state_d)
         S_ARM:    st_enc_d = 2'b01;
         S_RUN:    st_enc_d = 2'b10;
         S_SETTLE: st_enc_d = 2'b10;
         S_RESULT: begin
            st_enc_d   = 2'b11;
            win_led_d  = win_r_d;
            lose_led_d = ~win_r_d;
         end
         default:  st_enc_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         run_cnt_q  <= '0;
         hold_cnt_q <= '0;
         credits_q  <= CREDIT_W'(START_CREDITS);
         win_r_q    <= 1'b0;
         // held buttons must be released before they count as a press
         spin_q     <= 1'b1;
         coin_q     <= 1'b1;
         st_enc_q   <= 2'b00;
         win_led_q  <= 1'b0;
         lose_led_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         credits_q  <= credits_d;
         win_r_q    <= win_r_d;
         spin_q     <= spin_i;
         coin_q     <= coin_i;
         st_enc_q   <= st_enc_d;
         win_led_q  <= win_led_d;
         lose_led_q <= lose_led_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign state_o    = st_enc_q;
   assign credits_o  = credits_q;
   assign win_led_o  = win_led_q;
   assign lose_led_o = lose_led_q;
   assign busy_o     = busy_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: bench for slot_game_ctrl.
// A main instance (10 start credits) is checked every cycle against a game-level
// model. A second instance with 0 start credits covers the no-credit cases.
// The datapath stand-in raises done_i 10 cycles into RUN, or never when hung.
module tb_slot_game_ctrl;

   localparam int HOLD    = 4;
   localparam int TMO     = 20;
   localparam int RUN_LEN = 10;
   localparam int START   = 10;
   localparam int BET     = 1;
   localparam int PAY     = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, spin = 1'b0, coin = 1'b1, done = 1'b0, win = 1'b0;
   logic [1:0] state_o;
   logic [7:0] credits_o;
   logic       win_led_o, lose_led_o, busy_o, err_o;

   logic       rst2 = 1'b1, spin2 = 1'b0, coin2 = 1'b0, done2 = 1'b0, win2 = 1'b0;
   logic [1:0] state2;
   logic [7:0] credits2;
   logic       win_led2, lose_led2, busy2, err2;

   slot_game_ctrl #(.CREDIT_W(8), .START_CREDITS(START), .BET_COST(BET), .WIN_PAYOUT(PAY),
                    .RESULT_HOLD(HOLD), .RUN_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst), .spin_i(spin), .coin_i(coin), .done_i(done), .win_i(win),
      .state_o(state_o), .credits_o(credits_o), .win_led_o(win_led_o),
      .lose_led_o(lose_led_o), .busy_o(busy_o), .err_o(err_o));

   slot_game_ctrl #(.CREDIT_W(8), .START_CREDITS(0), .BET_COST(BET), .WIN_PAYOUT(PAY),
                    .RESULT_HOLD(HOLD), .RUN_TIMEOUT(TMO)) dut2 (
      .clk_i(clk), .rst_i(rst2), .spin_i(spin2), .coin_i(coin2), .done_i(done2), .win_i(win2),
      .state_o(state2), .credits_o(credits2), .win_led_o(win_led2),
      .lose_led_o(lose_led2), .busy_o(busy2), .err_o(err2));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // datapath stand-in, driven on the falling edge
   bit dp_hang = 1'b0;
   bit win_sel = 1'b0;
   int run_cnt = 0;
   always @(negedge clk) begin
      if (state_o == 2'b10) run_cnt++;
      else run_cnt = 0;
      done = !dp_hang && (state_o == 2'b10) && (run_cnt >= RUN_LEN);
      win  = done ? win_sel : 1'b0;
   end

   // game-level model: phase 0 idle, 1 arm, 2 spinning (incl. settle), 3 showing result
   int   m_cred = 0, m_t = 0;
   int   m_st = 0;
   bit   m_settle = 0, m_won = 0, m_err = 0, m_valid = 0, m_sp = 1, m_cp = 1;
   always @(posedge clk) begin
      int delta;
      bit sr, cr;
      if (rst) begin
         m_cred = START; m_st = 0; m_t = 0; m_settle = 0; m_won = 0; m_err = 0;
         m_sp = 1; m_cp = 1; m_valid = 1;
      end else begin
         sr = spin && !m_sp;
         cr = coin && !m_cp;
         m_sp = spin;
         m_cp = coin;
         delta = cr ? 1 : 0;
         m_err = 0;
         case (m_st)
            0: if (sr && m_cred >= BET) begin delta -= BET; m_st = 1; end
            1: begin m_st = 2; m_t = 0; m_settle = 0; end
            2: begin
               if (m_settle) begin
                  m_won = win;
                  if (win) delta += PAY;
                  m_st = 3; m_t = 0; m_settle = 0;
               end else if (done) begin
                  m_settle = 1;
               end else begin
                  m_t++;
                  if (m_t == TMO) begin delta += BET; m_err = 1; m_st = 0; end
               end
            end
            default: begin m_t++; if (m_t == HOLD) m_st = 0; end
         endcase
         m_cred += delta;
         if (m_cred > 255) m_cred = 255;
         if (m_cred < 0) m_cred = 0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_state", state_o, (m_st == 0) ? 0 : (m_st == 1) ? 1 : (m_st == 2) ? 2 : 3);
         check("model_credits", credits_o, m_cred);
         check("model_busy", busy_o, m_st != 0);
         check("model_win_led", win_led_o, (m_st == 3) && m_won);
         check("model_lose_led", lose_led_o, (m_st == 3) && !m_won);
         check("model_err", err_o, m_err);
      end
   end

   task automatic press_coin();
      coin = 1'b1;
      @(negedge clk);
      coin = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state_o == 2'b00) begin ok = 1; break; end
      end
      check(name, ok, 1);
   endtask

   task automatic run_spin(input bit w, output int first_st, output int first_cr,
                           output int n_run, output int n_res, output int res_cr,
                           output int n_wl, output int n_ll, output int n_err,
                           output int end_cr, output bit ok);
      win_sel = w;
      n_run = 0; n_res = 0; res_cr = -1; n_wl = 0; n_ll = 0; n_err = 0; end_cr = -1; ok = 0;
      @(negedge clk);
      spin = 1'b1;
      @(negedge clk);
      first_st = state_o;
      first_cr = credits_o;
      spin = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state_o == 2'b10) n_run++;
         if (state_o == 2'b11) begin
            if (n_res == 0) res_cr = credits_o;
            n_res++;
         end
         if (win_led_o) n_wl++;
         if (lose_led_o) n_ll++;
         if (err_o) n_err++;
         if (state_o == 2'b00) begin end_cr = credits_o; ok = 1; break; end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int fs, fc, nr, nres, rc, nwl, nll, ne, ec;
      bit ok;
      int pre;

      // reset with the coin button held down
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_state", state_o, 0);
      check("rst_credits", credits_o, START);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_leds", {win_led_o, lose_led_o}, 0);
      repeat (3) @(negedge clk);
      check("held_coin_no_credit", credits_o, 10);
      coin = 1'b0;
      @(negedge clk);

      // losing spin from 10
      run_spin(1'b0, fs, fc, nr, nres, rc, nwl, nll, ne, ec, ok);
      check("lose_done", ok, 1);
      check("lose_arm", fs, 1);
      check("lose_debit", fc, 9);
      check("lose_run_cycles", nr, 11);
      check("lose_result_cycles", nres, 4);
      check("lose_led_cycles", nll, 4);
      check("lose_win_led", nwl, 0);
      check("lose_end_credits", ec, 9);

      // winning spin from 10
      press_coin();
      check("coin_add", credits_o, 10);
      run_spin(1'b1, fs, fc, nr, nres, rc, nwl, nll, ne, ec, ok);
      check("win_done", ok, 1);
      check("win_debit", fc, 9);
      check("win_payout", rc, 29);
      check("win_led_cycles", nwl, 4);
      check("win_lose_led", nll, 0);
      check("win_run_cycles", nr, 11);

      // watchdog: datapath never finishes
      dp_hang = 1'b1;
      pre = credits_o;
      run_spin(1'b0, fs, fc, nr, nres, rc, nwl, nll, ne, ec, ok);
      check("wd_done", ok, 1);
      check("wd_debit", fc, 28);
      check("wd_run_cycles", nr, 20);
      check("wd_err_pulses", ne, 1);
      check("wd_no_result", nres, 0);
      check("wd_refund", ec, pre);
      dp_hang = 1'b0;

      // coin pressed mid-run is credited immediately
      win_sel = 1'b0;
      @(negedge clk);
      spin = 1'b1;
      repeat (4) @(negedge clk);
      spin = 1'b0;
      check("midrun_state", state_o, 2);
      press_coin();
      check("midrun_coin", credits_o, 29);
      wait_idle("midrun_idle");

      // fill to 251, then a winning spin saturates the payout
      for (int i = 0; i < 300 && credits_o < 251; i++) press_coin();
      check("fill_251", credits_o, 251);
      run_spin(1'b1, fs, fc, nr, nres, rc, nwl, nll, ne, ec, ok);
      check("sat_done", ok, 1);
      check("sat_debit", fc, 250);
      check("sat_payout", rc, 255);
      press_coin();
      check("sat_coin", credits_o, 255);

      // reset during RUN with spin still held
      @(negedge clk);
      spin = 1'b1;
      repeat (4) @(negedge clk);
      check("mr_in_run", state_o, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_state", state_o, 0);
      check("mr_credits", credits_o, 10);
      check("mr_leds", {win_led_o, lose_led_o}, 0);
      check("mr_busy", busy_o, 0);
      repeat (3) @(negedge clk);
      check("mr_held_spin_ignored", state_o, 0);
      spin = 1'b0;
      @(negedge clk);
      spin = 1'b1;
      @(negedge clk);
      spin = 1'b0;
      check("mr_fresh_spin_state", state_o, 1);
      check("mr_fresh_spin_credits", credits_o, 9);
      wait_idle("mr_idle");

      // no-credit instance
      rst2 = 1'b0;
      @(negedge clk);
      check("nc_rst_credits", credits2, 0);
      spin2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nc_state", state2, 0);
         check("nc_busy", busy2, 0);
         check("nc_credits", credits2, 0);
      end
      spin2 = 1'b0;
      @(negedge clk);
      coin2 = 1'b1;
      @(negedge clk);
      coin2 = 1'b0;
      check("nc_coin_one", credits2, 1);
      @(negedge clk);
      coin2 = 1'b1;
      spin2 = 1'b1;
      @(negedge clk);
      coin2 = 1'b0;
      spin2 = 1'b0;
      check("coin_spin_credits", credits2, 1);
      check("coin_spin_arm", state2, 1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
